// File: rtl/frac_baud_gen.sv
// Fractional baud-rate generator.
// A down-counter plus a fractional accumulator produce an oversampling
// strobe (rxTick) whose average period is actInt + actFrac/2^FracWidth
// clocks. From it come a mid-bit strobe (sampleTick) and a bit strobe
// (txTick). A new rate is requested with a valid/ready handshake. It is
// only switched in on a bit boundary, or at once while the generator is
// idle, so that no bit is ever stretched or cut short.
module frac_baud_gen #(
  parameter int IntWidth   = 16,
  parameter int FracWidth  = 4,
  parameter int Oversample = 16,
  parameter int MinDiv     = 2,
  parameter int ResetInt   = 651,
  parameter int ResetFrac  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IntWidth-1:0]  rateInt,
  input  logic [FracWidth-1:0] rateFrac,
  input  logic                 rateValid,
  output logic                 rateReady,
  input  logic                 rxRestart,
  output logic                 rxTick,
  output logic                 sampleTick,
  output logic                 txTick,
  output logic                 rateError
);

  localparam int OsWidth = $clog2(Oversample);
  localparam logic [IntWidth-1:0]  ResetIntVal  = IntWidth'(ResetInt);
  localparam logic [FracWidth-1:0] ResetFracVal = FracWidth'(ResetFrac);
  localparam logic [IntWidth:0]    ResetLoad    = (IntWidth+1)'(ResetInt - 1);
  localparam logic [IntWidth-1:0]  MinDivVal    = IntWidth'(MinDiv);
  localparam logic [OsWidth-1:0]   OsLast       = OsWidth'(Oversample - 1);
  localparam logic [OsWidth-1:0]   OsMid        = OsWidth'(Oversample / 2 - 1);

  logic [IntWidth-1:0]  actInt;
  logic [FracWidth-1:0] actFrac;
  logic [IntWidth-1:0]  pendInt;
  logic [FracWidth-1:0] pendFrac;
  logic                 pending;
  logic                 rateErrorReg;
  logic [IntWidth:0]    divCnt;
  logic [FracWidth-1:0] fracAcc;
  logic [OsWidth-1:0]   osCnt;

  logic                 divZero;
  logic                 tickRaw;
  logic                 txRaw;
  logic                 accept;
  logic                 applyRate;
  logic [FracWidth:0]   fracSum;
  logic [IntWidth:0]    actLoad;
  logic [IntWidth:0]    pendLoad;
  logic [IntWidth:0]    reloadCnt;

  // divCnt keeps one guard bit above IntWidth. The largest divisor plus a
  // fractional carry therefore still fits without wrapping.
  assign divZero   = (divCnt == '0);
  assign tickRaw   = enable && divZero;
  assign txRaw     = tickRaw && (osCnt == OsLast);
  assign rxTick    = tickRaw && !rxRestart && !reset;
  assign txTick    = rxTick && (osCnt == OsLast);
  assign sampleTick = rxTick && (osCnt == OsMid);
  assign rateReady = !pending;
  assign rateError = rateErrorReg;
  assign accept    = rateValid && !pending;
  assign applyRate = pending && (txRaw || !enable);
  assign fracSum   = {1'b0, fracAcc} + {1'b0, actFrac};
  assign actLoad   = {1'b0, actInt} - (IntWidth+1)'(1);
  assign pendLoad  = {1'b0, pendInt} - (IntWidth+1)'(1);
  assign reloadCnt = actLoad + (IntWidth+1)'(fracSum[FracWidth]);

  // Rate handshake: reject too-small divisors, otherwise hold the request
  // until the bit boundary (or idle) lets it replace the active rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      actInt       <= ResetIntVal;
      actFrac      <= ResetFracVal;
      pendInt      <= '0;
      pendFrac     <= '0;
      pending      <= 1'b0;
      rateErrorReg <= 1'b0;
    end else begin
      rateErrorReg <= accept && (rateInt < MinDivVal);
      if (applyRate) begin
        actInt  <= pendInt;
        actFrac <= pendFrac;
        pending <= 1'b0;
      end else if (accept && (rateInt >= MinDivVal)) begin
        pendInt  <= rateInt;
        pendFrac <= rateFrac;
        pending  <= 1'b1;
      end
    end
  end

  // Tick timing: a rate switch, idling or a restart realigns the counters.
  // Otherwise each tick reloads the divisor, adding one clock whenever the
  // fractional accumulator overflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt  <= ResetLoad;
      fracAcc <= '0;
      osCnt   <= '0;
    end else if (applyRate) begin
      divCnt  <= pendLoad;
      fracAcc <= '0;
      osCnt   <= '0;
    end else if (!enable || rxRestart) begin
      divCnt  <= actLoad;
      fracAcc <= '0;
      osCnt   <= '0;
    end else if (divZero) begin
      divCnt  <= reloadCnt;
      fracAcc <= fracSum[FracWidth-1:0];
      osCnt   <= osCnt + OsWidth'(1);
    end else begin
      divCnt  <= divCnt - (IntWidth+1)'(1);
    end
  end

endmodule

// File: doc/frac_baud_gen.md
FRAC_BAUD_GEN -- requirements
Module: frac_baud_gen

Interface
REQ-001 SHALL have parameter IntWidth, default 16: integer divisor width.
REQ-002 SHALL have parameter FracWidth, default 4: fractional divisor width.
REQ-003 SHALL have parameter Oversample, default 16: rx ticks per bit, power of two, 4..32.
REQ-004 SHALL have parameter MinDiv, default 2: smallest legal rateInt.
REQ-005 SHALL have parameter ResetInt, default 651, and ResetFrac, default 1: the active rate after reset.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 enable  in  1  run the tick counters.
REQ-009 rateInt  in  IntWidth  requested integer clocks per rx tick.
REQ-010 rateFrac  in  FracWidth  requested fractional part, in units of 2^-FracWidth.
REQ-011 rateValid  in  1  rate request.
REQ-012 rateReady  out  1  request can be accepted.
REQ-013 rxRestart  in  1  realign rx timing to a start edge.
REQ-014 rxTick  out  1  one-cycle oversample strobe.
REQ-015 sampleTick  out  1  one-cycle mid-bit strobe.
REQ-016 txTick  out  1  one-cycle bit strobe.
REQ-017 rateError  out  1  one-cycle pulse: request rejected.

Function
REQ-018 SHALL hold active registers actInt and actFrac, a down-counter divCnt (IntWidth+1 bits), an accumulator fracAcc (FracWidth bits), and a counter osCnt (log2(Oversample) bits).
REQ-019 rxTick SHALL equal enable && divCnt==0, decoded combinationally from registers.
REQ-020 On rxTick: {carry,fracAcc} <= fracAcc+actFrac; divCnt <= actInt-1+carry; osCnt <= osCnt+1, wrapping; otherwise divCnt decrements while enable is high.
REQ-021 Average rxTick period SHALL be exactly actInt+actFrac/2^FracWidth clocks; each individual period SHALL be actInt or actInt+1.
REQ-022 txTick SHALL equal rxTick && osCnt==Oversample-1.
REQ-023 sampleTick SHALL equal rxTick && osCnt==Oversample/2-1.
REQ-024 While enable is low: divCnt=actInt-1, fracAcc=0, osCnt=0, and all ticks are 0.
REQ-025 The first rxTick after enable rises SHALL occur in the actInt-th enabled cycle.
REQ-026 rxRestart SHALL set divCnt=actInt-1, fracAcc=0 and osCnt=0. It beats a coincident rxTick: no tick is emitted in that cycle.
REQ-027 rateReady SHALL be high exactly when no request is pending.
REQ-028 A request is accepted when rateValid && rateReady are both high.
REQ-029 An accepted request with rateInt<MinDiv SHALL pulse rateError in the next cycle, leave the active rate unchanged, and keep rateReady high.
REQ-030 An accepted legal request SHALL be latched as pending and rateReady driven low.
REQ-031 A pending rate SHALL be applied on the clock edge of the next txTick, or on the next edge if enable is low.
REQ-032 Applying a rate SHALL load actInt/actFrac, set divCnt=newInt-1, fracAcc=0 and osCnt=0, and raise rateReady in the following cycle.
REQ-033 If a txTick and rxRestart coincide with a pending rate, the pending rate SHALL be applied and rxRestart still honoured.
REQ-034 divCnt arithmetic SHALL be unsigned with one guard bit, so that actInt = 2^IntWidth-1 with a carry does not overflow.

Reset
REQ-035 On reset: actInt=ResetInt, actFrac=ResetFrac, no request pending, rateReady=1, divCnt=ResetInt-1, fracAcc=0, osCnt=0.
REQ-036 On reset: rxTick, sampleTick, txTick and rateError SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL discard any pending rate and override every other input.

Verification
REQ-038 Load rateInt=4, rateFrac=0 with enable=1 -> rxTick every 4 cycles, txTick every 64 cycles, sampleTick on the 8th rxTick of each group.
REQ-039 rateInt=4, rateFrac=8 (FracWidth=4) -> rxTick periods alternate 4,5,4,5; 32 rxTicks span exactly 144 cycles; txTick every 72 cycles.
REQ-040 Request rateInt=8 in mid-bit -> rateReady low until the next txTick; the old period holds until then, then the period is 8 and the next txTick comes 128 cycles later.
REQ-041 Request rateInt=1 -> one-cycle rateError pulse, rateReady stays 1, rxTick period unchanged.
REQ-042 rxRestart in the same cycle as rxTick -> no tick that cycle, the next rxTick actInt cycles later, sampleTick on the 8th following rxTick.
REQ-043 Reset while a rate is pending -> all outputs 0, rateReady=1, and after enable the period is ResetInt/ResetFrac (651 then 652 every 16th tick).
